mimo_readout: RTL and testbench

MIMO_READOUT -- requirements
Module: mimo_readout

---
 rtl/mimo_readout.sv | 179 +++++++++++++++++
 tb/tb_mimo_readout.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mimo_readout.sv
// ============================================================================
// mimo_readout: sequential unit-major readout of a bank of RAM units into a
// valid/ready stream, with optional clear-on-read.  Rev 1.0
// ============================================================================
`default_nettype none

module mimo_readout #(
  parameter int datBit   = 17,
  parameter int addrBit  = 9,
  parameter int totUnits = 31,
  localparam int UW      = (totUnits > 0) ? $clog2(totUnits + 1) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           clr_en,
  output logic                           busy,
  output logic                           done,
  output logic [addrBit:0]               ram_ra,
  input  logic [totUnits:0][datBit:0]    ram_rd,
  output logic [totUnits:0]              ram_we,
  output logic [addrBit:0]               ram_wa,
  output logic [datBit:0]                ram_wd,
  output logic [datBit:0]                m_data,
  output logic [UW-1:0]                  m_unit,
  output logic [addrBit:0]               m_addr,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Issue-side counters and latched clear mode
  logic [addrBit:0] r_addr;
  logic [UW-1:0]    r_unit;
  logic             r_clr;

  // Tag of the read whose data arrives on ram_rd this cycle
  logic             r_pend_vld;
  logic [UW-1:0]    r_pend_unit;
  logic [addrBit:0] r_pend_addr;
  logic             r_pend_last;

  // Two-entry output FIFO
  logic [datBit:0]  r_f_data [2];
  logic [UW-1:0]    r_f_unit [2];
  logic [addrBit:0] r_f_addr [2];
  logic             r_f_last [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_cnt;

  logic             w_pop;
  logic [2:0]       w_occ;
  logic             w_issue;
  logic             w_last_issue;

  assign w_pop        = (r_cnt != 2'd0) && m_ready;
  assign w_occ        = {1'b0, r_cnt} + {2'b00, r_pend_vld} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_SCAN) && (w_occ < 3'd2);
  assign w_last_issue = (r_unit == UW'(totUnits)) && (&r_addr);

  assign ram_ra  = r_addr;
  assign ram_wa  = r_addr;
  assign ram_wd  = '0;

  assign m_valid = (r_cnt != 2'd0);
  assign m_data  = r_f_data[r_rp];
  assign m_unit  = r_f_unit[r_rp];
  assign m_addr  = r_f_addr[r_rp];
  assign m_last  = r_f_last[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ram_we      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (w_issue && w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && r_f_last[r_rp]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Write port clears the very location being read; RAM returns old data
    for (int u = 0; u <= totUnits; u++) begin
      if (r_unit == UW'(u)) ram_we[u] = w_issue && r_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_unit <= '0;
      r_clr  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) r_clr <= clr_en;
      if (w_issue) begin
        if (&r_addr) begin
          r_addr <= '0;
          r_unit <= w_last_issue ? '0 : r_unit + UW'(1);
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_unit <= '0;
      r_pend_addr <= '0;
      r_pend_last <= 1'b0;
    end else begin
      r_pend_vld <= w_issue;
      if (w_issue) begin
        r_pend_unit <= r_unit;
        r_pend_addr <= r_addr;
        r_pend_last <= w_last_issue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_f_data[i] <= '0;
        r_f_unit[i] <= '0;
        r_f_addr[i] <= '0;
        r_f_last[i] <= 1'b0;
      end
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (r_pend_vld) begin
        r_f_data[r_wp] <= ram_rd[r_pend_unit];
        r_f_unit[r_wp] <= r_pend_unit;
        r_f_addr[r_wp] <= r_pend_addr;
        r_f_last[r_wp] <= r_pend_last;
        r_wp           <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_pend_vld} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mimo_readout.sv
// ============================================================================
// tb_mimo_readout: directed and randomized passes against a RAM-contents model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mimo_readout;

  localparam int DB = 7;
  localparam int AB = 1;
  localparam int TU = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              clr_en = 1'b0;
  logic              m_ready = 1'b0;
  logic              busy, done, m_valid, m_last;
  logic [AB:0]       ram_ra, ram_wa, m_addr;
  logic [TU:0][DB:0] ram_rd;
  logic [TU:0]       ram_we;
  logic [DB:0]       ram_wd, m_data;
  logic [0:0]        m_unit;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram_m  [2][4];
  logic [7:0] shadow [2][4];
  logic [7:0] pl_val [2][4];
  logic       pl_en = 1'b0;

  mimo_readout #(.datBit(DB), .addrBit(AB), .totUnits(TU)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_en(clr_en),
    .busy(busy), .done(done), .ram_ra(ram_ra), .ram_rd(ram_rd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_wd(ram_wd),
    .m_data(m_data), .m_unit(m_unit), .m_addr(m_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Registered-read RAM with read-before-write
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ram_rd[u] <= ram_m[u][ram_ra];
      if (pl_en) begin
        for (int a = 0; a < 4; a++) ram_m[u][a] <= pl_val[u][a];
      end else if (ram_we[u]) begin
        ram_m[u][ram_wa] <= 8'h00;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, m_valid, m_last, ram_we}, 0);
    chk({tag, "_addr"}, {ram_ra, ram_wa, m_addr, m_unit}, 0);
    chk({tag, "_data"}, m_data, 0);
  endtask

  task automatic preload(input bit rnd);
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 4; a++) begin
        pl_val[u][a] = rnd ? 8'($urandom) : 8'(16 * u + a);
        shadow[u][a] = pl_val[u][a];
      end
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready
  task automatic run_pass(input bit clr, input int rmode, input bit restart);
    int n, cyc, issued, first_c, last_c;
    bit held;
    logic [7:0] hd;
    logic [3:0] hm;
    n = 0; cyc = 0; issued = 0; first_c = 0; last_c = 0; held = 0; hd = 0; hm = 0;
    clr_en = clr;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("busy_after_start", busy, 1);
    while (n < 8 && cyc < 300) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = restart && (n == 3 || n == 7);
      #1;
      issued += $countones(ram_we);
      if (held) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hd);
        chk("stall_meta", {m_unit, m_addr, m_last}, hm);
      end
      chk("done_early", done, 0);
      if (m_valid && m_ready) begin
        chk("word_data", m_data, shadow[n / 4][n % 4]);
        chk("word_unit", m_unit, n / 4);
        chk("word_addr", m_addr, n % 4);
        chk("word_last", m_last, (n == 7));
        if (n == 0) first_c = cyc;
        last_c = cyc;
        n++;
        held = 0;
      end else if (m_valid) begin
        held = 1;
        hd   = m_data;
        hm   = {m_unit, m_addr, m_last};
      end
      if (clr) chk("outstanding_le_2", (issued - n) <= 2, 1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("word_count", n, 8);
    chk("done_pulse", done, 1);
    chk("valid_after_last", m_valid, 0);
    if (clr) chk("clear_writes", issued, 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_single", done, 0);
    chk("start_in_done_ignored", busy, 0);
    if (rmode == 0) chk("throughput", last_c - first_c, 7);
    if (clr) begin
      for (int u = 0; u < 2; u++)
        for (int a = 0; a < 4; a++) shadow[u][a] = 8'h00;
    end
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 4; a++) chk("ram_contents", ram_m[u][a], shadow[u][a]);
  endtask

  initial begin
    int n, cyc;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("ram_wd_zero", ram_wd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    preload(1'b0);
    run_pass(1'b0, 0, 1'b0);
    run_pass(1'b1, 0, 1'b0);
    run_pass(1'b0, 0, 1'b0);

    preload(1'b0);
    run_pass(1'b1, 1, 1'b0);

    preload(1'b0);
    run_pass(1'b0, 0, 1'b1);

    // Reset in the middle of a pass
    preload(1'b0);
    clr_en  = 1'b0;
    m_ready = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 50) begin
      #1;
      if (m_valid) n++;
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_words", n, 4);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_zero("post_reset");
    @(negedge clk);
    run_pass(1'b0, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      preload(1'b1);
      run_pass(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
